// File: rtl/ysyx_25020047_exu_muldiv.sv
// ysyx_25020047_exu_muldiv: iterative RV32M multiply/divide unit (radix-2 shift-add multiplier, restoring divider).
// Optional feature: define MULDIV_EARLY_OUT_EN to let trivial ops (b==0, signed overflow, MUL* by zero) finish in one busy cycle.
module ysyx_25020047_exu_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [2:0]        op;
    logic [CNT_W-1:0]  cnt, cnt_init;
    logic [2*XLEN-1:0] prod, prod_nxt, sprod;
    logic [XLEN-1:0]   rem, rem_nxt, mcand, spec_res, spec_res_in;
    logic              neg, spec;

    logic              sgn_a, sgn_b, sa, sb, neg_in, div0, ovf, mul_zero, spec_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, shifted, diff;
    logic [XLEN-1:0]   q_nxt, div_res, div_fix, mul_res, res;

    // Operand preparation at accept: signed ops keep magnitudes, the result sign is remembered,
    // and RISC-V special cases get their architectural result precomputed.
    always_comb begin
        sgn_a       = in_op[2] ? ~in_op[0] : (in_op[1] ^ in_op[0]);
        sgn_b       = in_op[2] ? ~in_op[0] : (in_op[1:0] == 2'b01);
        sa          = in_a[XLEN-1] & sgn_a;
        sb          = in_b[XLEN-1] & sgn_b;
        neg_in      = sa ^ (sb & ~in_op[1]);
        a_mag       = sa ? -in_a : in_a;
        b_mag       = sb ? -in_b : in_b;
        div0        = in_op[2] & (in_b == '0);
        ovf         = in_op[2] & ~in_op[0] & (in_a == MIN) & (in_b == '1);
        mul_zero    = ~in_op[2] & ((in_a == '0) | (in_b == '0));
        spec_in     = div0 | ovf | mul_zero;
        spec_res_in = div0 ? (in_op[1] ? in_a : '1) : ovf ? (in_op[1] ? '0 : MIN) : '0;
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign cnt_init = spec_in ? CNT_W'(1) : CNT_W'(XLEN);
`else
    assign cnt_init = CNT_W'(XLEN);
`endif

    // One iteration: multiply adds the multiplicand on the low product bit and shifts right;
    // divide shifts the next dividend bit into the remainder and keeps the trial difference if non-negative.
    always_comb begin
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
        shifted  = {rem, prod[XLEN-1]};
        diff     = shifted - {1'b0, mcand};
        rem_nxt  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        q_nxt    = {prod[XLEN-2:0], ~diff[XLEN]};
        prod_nxt = op[2] ? {prod[2*XLEN-1:XLEN], q_nxt} : {mul_sum, prod[XLEN-1:1]};
        sprod    = neg ? -prod_nxt : prod_nxt;
        mul_res  = (op == 3'd0) ? sprod[XLEN-1:0] : sprod[2*XLEN-1:XLEN];
        div_res  = op[1] ? rem_nxt : prod_nxt[XLEN-1:0];
        div_fix  = neg ? -div_res : div_res;
        res      = spec ? spec_res : op[2] ? div_fix : mul_res;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: flush overrides everything, otherwise IDLE -> BUSY -> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        if (flush)                                 state_nxt = IDLE;
        else if (state == IDLE && in_valid)        state_nxt = BUSY;
        else if (state == BUSY && cnt == CNT_W'(1)) state_nxt = DONE;
        else if (state == DONE && out_ready)       state_nxt = IDLE;
    end

    // Datapath: capture on accept, iterate while busy, publish the fixed-up result on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op         <= '0;
            cnt        <= '0;
            prod       <= '0;
            rem        <= '0;
            mcand      <= '0;
            neg        <= 1'b0;
            spec       <= 1'b0;
            spec_res   <= '0;
            out_result <= '0;
            out_rd     <= '0;
        end else if (!flush && state == IDLE && in_valid) begin
            op       <= in_op;
            cnt      <= cnt_init;
            prod     <= {{XLEN{1'b0}}, in_op[2] ? a_mag : b_mag};
            rem      <= '0;
            mcand    <= in_op[2] ? b_mag : a_mag;
            neg      <= neg_in;
            spec     <= spec_in;
            spec_res <= spec_res_in;
            out_rd   <= in_rd;
        end else if (!flush && state == BUSY) begin
            cnt  <= cnt - CNT_W'(1);
            prod <= prod_nxt;
            rem  <= rem_nxt;
            if (cnt == CNT_W'(1)) out_result <= res;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_ysyx_25020047_exu_muldiv.sv
// tb_ysyx_25020047_exu_muldiv: randomized and directed checks of the muldiv unit against an arithmetic reference model.
module tb_ysyx_25020047_exu_muldiv;
    localparam logic [31:0] MIN = 32'h80000000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [2:0]  in_op = '0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [4:0]  in_rd = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    int          total = 0, passed = 0;

    ysyx_25020047_exu_muldiv dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else passed++;
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin sp = sa * sb; r = sp[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: if (b == 0) r = '1; else if (a == MIN && b == '1) r = MIN; else begin sp = sa / sb; r = sp[31:0]; end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: if (b == 0) r = a; else begin sp = sa % sb; r = sp[31:0]; end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (b == 0 || (op[2] && !op[0] && a == MIN && b == '1) || (!op[2] && a == 0)) return 2;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return MIN;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input int hold);
        logic [31:0] exp;
        int lat, t;
        exp = ref_model(op, a, b);
        @(negedge clk);
        t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        check("ready_before", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_op = 3'($urandom); in_a = $urandom; in_b = $urandom; in_rd = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        check($sformatf("latency op%0d", op), 64'(lat), 64'(exp_lat(op, a, b)));
        check($sformatf("result op%0d a=%h b=%h", op, a, b), 64'(out_result), 64'(exp));
        check("rd", 64'(out_rd), 64'(rd));
        repeat (hold) begin
            @(negedge clk);
            check("hold", {out_valid, in_ready, out_rd, out_result}, {1'b1, 1'b0, rd, exp});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after", {busy, out_valid, in_ready}, 3'b001);
    endtask

    task automatic throughput();
        int cyc, last, acc, t;
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd0; in_a = 32'd3; in_b = 32'd5; out_ready = 1'b1;
        cyc = 0; last = 0; acc = 0;
        while (acc < 3 && cyc < 300) begin
            if (in_ready) begin
                if (acc > 0) check("throughput", 64'(cyc - last), 64'd34);
                last = cyc;
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        check("accepts", 64'(acc), 64'd3);
        in_valid = 1'b0;
        t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        check("drained", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int seen, t;
        repeat (2) @(negedge clk);
        check("reset", {in_ready, out_valid, busy, out_rd, out_result}, {3'b100, 5'd0, 32'd0});
        rst_n = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd1, 0);
        run_op(3'd1, MIN, MIN, 5'd2, 0);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 0);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 0);
        run_op(3'd4, -32'd7, 32'd2, 5'd5, 0);
        run_op(3'd6, -32'd7, 32'd2, 5'd6, 0);
        run_op(3'd5, 32'd100, 32'd7, 5'd7, 0);
        run_op(3'd7, 32'd100, 32'd7, 5'd8, 0);
        run_op(3'd5, 32'd5, 32'd0, 5'd9, 0);
        run_op(3'd6, 32'd5, 32'd0, 5'd10, 0);
        run_op(3'd4, MIN, 32'hFFFFFFFF, 5'd11, 0);
        run_op(3'd6, MIN, 32'hFFFFFFFF, 5'd12, 0);
        run_op(3'd1, 32'd0, 32'h12345678, 5'd13, 0);
        run_op(3'd4, 32'd1234567, 32'hFFFFFF85, 5'd14, 10);

        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd5; in_a = 32'd100; in_b = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_a = 32'd9; in_b = 32'd9;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_busy", {busy, out_valid, in_ready}, 3'b001);
        seen = 0;
        repeat (40) begin @(negedge clk); seen |= int'(out_valid); end
        check("flush_no_valid", 64'(seen), 64'd0);
        run_op(3'd7, 32'hDEADBEEF, 32'd1000, 5'd15, 0);

        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_op = 3'd0; in_a = 32'd2; in_b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle", {busy, in_ready}, 2'b01);

        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd0; in_a = 32'd2; in_b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 100) begin @(negedge clk); t++; end
        check("flush_done_reached", 64'(out_valid), 64'd1);
        out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; flush = 1'b0;
        check("flush_done", {busy, out_valid, in_ready}, 3'b001);

        for (int i = 0; i < 40; i++)
            run_op(3'($urandom), pick(), pick(), 5'($urandom), $urandom_range(0, 2));

        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd4; in_a = 32'd1000; in_b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {in_ready, out_valid, busy, out_rd, out_result}, {3'b100, 5'd0, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        throughput();
        run_op(3'd6, 32'hFFFFFF9C, 32'd7, 5'd31, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
